instr_loader: RTL and testbench
===============================

# instr_loader

Byte-stream program loader: the write side of the instruction memory. It receives a framed byte stream with a valid/ready handshake and writes each instruction into byte-wide memory cells. Each instruction's high byte goes at address A and its low byte at A+1, so a read that concatenates {cell[A], cell[A+1]} returns the word that was loaded. It sits between the host link (UART receiver or testbench) and the instruction memory write port, and holds the CPU in reset while a frame is in flight.

## Interface
- WORD_LEN, 16, instruction width in bits (two cells)
- ADDR_LEN, 16, memory byte-address width
- MEM_CELL_SIZE, 8, memory cell width; must equal the stream byte width
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset: rst, synchronous, active-high
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte; a byte transfers on a cycle with in_valid && in_ready
- mem_we  out  1  one-cycle cell write strobe
- mem_addr  out  ADDR_LEN  cell address
- mem_wdata  out  MEM_CELL_SIZE  cell data
- cpu_hold  out  1  high while a frame is being loaded
- done  out  1  one-cycle pulse: frame complete
- err  out  1  one-cycle pulse: frame checksum mismatch

## Operation
- Frame format, in order:
  - SYNC
  - ADDR_HI, ADDR_LO: start byte address
  - CNT_HI, CNT_LO: instruction count N, 16-bit
  - 2N data bytes, high byte of each word first
  - CSUM (present only when checksum is enabled)
- States:
  - IDLE: a non-SYNC byte is accepted and discarded. SYNC moves to ADDR_HI.
  - ADDR_HI → ADDR_LO → CNT_HI → CNT_LO: one byte each.
  - CNT_LO: if N=0, go to CSUM (or FINISH when checksum is off). Otherwise go to DATA.
  - DATA: each byte produces one cell write, then the address increments by 1. After byte 2N, go to CSUM or FINISH.
  - CSUM: compare the received byte with the running checksum, then go to FINISH.
  - FINISH: one cycle; pulses done (and err on mismatch), then returns to IDLE.
- Address wraps modulo 2^ADDR_LEN (FFFF → 0000).
- Remaining-byte counter is 17 bits wide, loaded with 2N.
- A SYNC value inside ADDR/CNT/DATA/CSUM is treated as an ordinary payload byte.
- Writes are never suppressed. If the checksum fails, the cells are already written and err only flags the frame.
- Reset mid-frame: return to IDLE, drop cpu_hold, clear counters. Cells already written stay written.

## Timing
- Reset values:
  - in_ready = 0 in the reset cycle, then 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 0, done = 0, err = 0.
- in_ready is 1 in every state except FINISH. The loader never back-pressures mid-frame; the write port takes one cell per cycle.
- A DATA byte accepted at edge N produces mem_we = 1 with its address and data during cycle N+1 (registered, 1-cycle latency).
- cpu_hold goes high the cycle after SYNC is accepted and stays high through the FINISH cycle.
- done and err are asserted in the FINISH cycle, which is the cycle after the last byte is accepted.
- Back-to-back frames are allowed: a SYNC may be presented on the cycle after FINISH.

## Configuration
- INSTR_LOADER_CSUM_EN
  - Defined: the CSUM byte is expected. The running checksum is the XOR of all 2N data bytes. On mismatch, err pulses together with done.
  - Undefined: there is no CSUM state, DATA (or CNT_LO when N=0) goes directly to FINISH, and err is tied to 0.

## Structure
- Package instr_loader_pkg:
  - state enum (IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM, FINISH)
  - SYNC_BYTE default
  - frame header length constant
- Sub-module instr_loader_csum: XOR accumulator with clear and enable inputs. Instantiated only under INSTR_LOADER_CSUM_EN.

## Test plan
- Normal frame: A5 00 10 00 02 12 34 AB CD 40 → four writes in consecutive cycles: 0010←12, 0011←34, 0012←AB, 0013←CD; done=1, err=0; cpu_hold high from after A5 through FINISH.
- Bad checksum: same frame with CSUM 41 → same four writes; done=1 and err=1 in the same cycle.
- Wrap and noise: leading bytes 00 FF (discarded, no writes), then A5 FF FF 00 01 DE AD 73 → writes FFFF←DE, 0000←AD; done=1.
- Zero count: A5 00 00 00 00 00 → no mem_we; done=1 one cycle after the CSUM byte.
- Reset mid-DATA: rst after 12 34 in the first frame → cpu_hold=0, state IDLE, next frame loads correctly.
- In-band SYNC: data bytes A5 A5 at 0020 → written as data, no frame restart.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
package instr_loader_pkg;

  localparam int unsigned WORD_LEN      = 16;
  localparam int unsigned ADDR_LEN      = 16;
  localparam int unsigned MEM_CELL_SIZE = 8;
  localparam int unsigned CNT_LEN       = 17;
  localparam int unsigned HDR_LEN       = 5;

  localparam logic [MEM_CELL_SIZE-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    FINISH
  } state_t;

endpackage

// File: rtl/instr_loader_csum.sv
// Running XOR of the data bytes of one frame; cleared at frame start.
module instr_loader_csum
  import instr_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [MEM_CELL_SIZE-1:0] data,
  output logic [MEM_CELL_SIZE-1:0] csum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ data;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream loader writing instructions into byte-wide memory cells.
// Optional trailing XOR checksum enabled by defining INSTR_LOADER_CSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MEM_CELL_SIZE-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDR_LEN-1:0]      mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

`ifdef INSTR_LOADER_CSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = FINISH;
`endif

  state_t                     state, state_n;
  logic [ADDR_LEN-1:0]        addr, addr_n;
  logic [CNT_LEN-1:0]         rem, rem_n;
  logic [MEM_CELL_SIZE-1:0]   cnt_hi, cnt_hi_n;
  logic                       we_n, ready_n, hold_n, done_n;
  logic [ADDR_LEN-1:0]        waddr_n;
  logic [MEM_CELL_SIZE-1:0]   wdata_n;
  logic                       fire_c;
  logic [2*MEM_CELL_SIZE-1:0] count_c;

  assign fire_c  = in_valid && in_ready;
  assign count_c = {cnt_hi, in_data};

`ifdef INSTR_LOADER_CSUM_EN
  logic                     csum_clr_c, csum_en_c, err_n;
  logic [MEM_CELL_SIZE-1:0] csum_c;

  instr_loader_csum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (csum_clr_c),
    .en   (csum_en_c),
    .data (in_data),
    .csum (csum_c)
  );
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    rem_n    = rem;
    cnt_hi_n = cnt_hi;
    we_n     = 1'b0;
    waddr_n  = mem_addr;
    wdata_n  = mem_wdata;
`ifdef INSTR_LOADER_CSUM_EN
    csum_clr_c = 1'b0;
    csum_en_c  = 1'b0;
    err_n      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fire_c && in_data == SYNC_BYTE) begin
          state_n = ADDR_HI;
`ifdef INSTR_LOADER_CSUM_EN
          csum_clr_c = 1'b1;
`endif
        end
      end
      ADDR_HI: begin
        if (fire_c) begin
          addr_n  = {in_data, addr[MEM_CELL_SIZE-1:0]};
          state_n = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (fire_c) begin
          addr_n  = {addr[ADDR_LEN-1:MEM_CELL_SIZE], in_data};
          state_n = CNT_HI;
        end
      end
      CNT_HI: begin
        if (fire_c) begin
          cnt_hi_n = in_data;
          state_n  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (fire_c) begin
          rem_n   = CNT_LEN'(count_c) << 1;
          state_n = (count_c == '0) ? POST_DATA : DATA;
        end
      end
      DATA: begin
        if (fire_c) begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = in_data;
          addr_n  = addr + ADDR_LEN'(1);
          rem_n   = rem - CNT_LEN'(1);
`ifdef INSTR_LOADER_CSUM_EN
          csum_en_c = 1'b1;
`endif
          if (rem == CNT_LEN'(1)) state_n = POST_DATA;
        end
      end
`ifdef INSTR_LOADER_CSUM_EN
      CSUM: begin
        if (fire_c) begin
          err_n   = (in_data != csum_c);
          state_n = FINISH;
        end
      end
`endif
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n != FINISH);
    hold_n  = (state_n != IDLE);
    done_n  = (state_n == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      cnt_hi    <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      rem       <= rem_n;
      cnt_hi    <= cnt_hi_n;
      in_ready  <= ready_n;
      mem_we    <= we_n;
      mem_addr  <= waddr_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      done      <= done_n;
    end
  end

`ifdef INSTR_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_n;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a frame-level model.
module tb_instr_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  typedef struct {
    int   cyc;
    logic err;
  } dn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, done, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stray_err = 0;

  logic [7:0] byte_q[$];
  bit         hold_q[$];
  bit         last_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] noise_q[$];
  wr_t        exp_w[$];
  bit         exp_err[$];
  int         frame_end[$];
  int         acc_q[$];
  wr_t        mon_w[$];
  dn_t        mon_d[$];

  instr_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write port and completion events, tagged with cycle
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) mon_w.push_back('{mem_addr, mem_wdata, cyc});
    if (done === 1'b1) mon_d.push_back('{cyc, err});
    if (err === 1'b1 && done !== 1'b1) stray_err++;
  end

  task automatic clear_exp();
    byte_q.delete(); hold_q.delete(); last_q.delete();
    exp_w.delete(); exp_err.delete(); frame_end.delete();
    pay_q.delete(); noise_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b, input bit hold);
    byte_q.push_back(b);
    hold_q.push_back(hold);
    last_q.push_back(1'b0);
  endtask

  // Frame model: build the byte stream and the writes/flags it must cause
  task automatic add_frame(input logic [15:0] a, input bit bad, input int noise);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  b;
    n  = 16'(pay_q.size() / 2);
    cs = 8'h00;
    foreach (noise_q[i]) push_byte(noise_q[i], 1'b0);
    noise_q.delete();
    for (int i = 0; i < noise; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h5A;
      push_byte(b, 1'b0);
    end
    push_byte(SYNC, 1'b1);
    push_byte(a[15:8], 1'b1);
    push_byte(a[7:0], 1'b1);
    push_byte(n[15:8], 1'b1);
    push_byte(n[7:0], 1'b1);
    for (int i = 0; i < 2 * int'(n); i++) begin
      exp_w.push_back('{16'(a + 16'(i)), pay_q[i], byte_q.size()});
      push_byte(pay_q[i], 1'b1);
      cs = cs ^ pay_q[i];
    end
`ifdef INSTR_LOADER_CSUM_EN
    push_byte(bad ? (cs ^ 8'h01) : cs, 1'b1);
    exp_err.push_back(bad);
`else
    exp_err.push_back(1'b0);
`endif
    last_q[last_q.size() - 1] = 1'b1;
    frame_end.push_back(byte_q.size() - 1);
    pay_q.delete();
  endtask

  task automatic send_stream(input int gap_max);
    int w;
    @(negedge clk);
    mon_w.delete(); mon_d.delete(); acc_q.delete(); stray_err = 0;
    for (int j = 0; j < byte_q.size(); j++) begin
      in_valid = 1'b1;
      in_data  = byte_q[j];
      w = 0;
      while (in_ready !== 1'b1 && w < 8) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall byte %0d: in_ready=%b required 1 within 8 cycles", j, in_ready);
      end
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      checks++;
      if (cpu_hold !== hold_q[j]) begin
        errors++;
        $display("FAIL cpu_hold byte %0d: got %b expected %b", j, cpu_hold, hold_q[j]);
      end
      checks++;
      if (in_ready !== !last_q[j]) begin
        errors++;
        $display("FAIL in_ready byte %0d: got %b expected %b", j, in_ready, !last_q[j]);
      end
      in_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_results(input string tag);
    int nw, nd;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (mon_w.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", tag, mon_w.size(), exp_w.size());
    end
    nw = (mon_w.size() < exp_w.size()) ? mon_w.size() : exp_w.size();
    for (int i = 0; i < nw; i++) begin
      checks++;
      if (mon_w[i].addr !== exp_w[i].addr || mon_w[i].data !== exp_w[i].data ||
          mon_w[i].cyc !== acc_q[exp_w[i].cyc]) begin
        errors++;
        $display("FAIL %s write %0d: got %h<-%h @%0d expected %h<-%h @%0d", tag, i,
                 mon_w[i].addr, mon_w[i].data, mon_w[i].cyc,
                 exp_w[i].addr, exp_w[i].data, acc_q[exp_w[i].cyc]);
      end
    end
    checks++;
    if (mon_d.size() !== frame_end.size()) begin
      errors++;
      $display("FAIL %s done count: got %0d expected %0d", tag, mon_d.size(), frame_end.size());
    end
    nd = (mon_d.size() < frame_end.size()) ? mon_d.size() : frame_end.size();
    for (int i = 0; i < nd; i++) begin
      checks++;
      if (mon_d[i].cyc !== acc_q[frame_end[i]] || mon_d[i].err !== exp_err[i]) begin
        errors++;
        $display("FAIL %s done %0d: got @%0d err=%b expected @%0d err=%b", tag, i,
                 mon_d[i].cyc, mon_d[i].err, acc_q[frame_end[i]], exp_err[i]);
      end
    end
    checks++;
    if (stray_err !== 0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: stray_err=%0d cpu_hold=%b expected 0 and 0", tag, stray_err, cpu_hold);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== 29'h0) begin
      errors++;
      $display("FAIL reset outputs: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_normal();
    clear_exp();
    pay_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    add_frame(16'h0010, 1'b0, 0);
    send_stream(0);
    check_results("normal");
  endtask

  task automatic test_bad_csum();
    clear_exp();
    pay_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    add_frame(16'h0010, 1'b1, 0);
    send_stream(0);
    check_results("bad_csum");
  endtask

  task automatic test_wrap_noise();
    clear_exp();
    noise_q = '{8'h00, 8'hFF};
    pay_q = '{8'hDE, 8'hAD};
    add_frame(16'hFFFF, 1'b0, 0);
    send_stream(0);
    check_results("wrap_noise");
  endtask

  task automatic test_zero_count();
    clear_exp();
    add_frame(16'h0000, 1'b0, 0);
    send_stream(0);
    check_results("zero_count");
  endtask

  task automatic test_inband_sync();
    clear_exp();
    pay_q = '{8'hA5, 8'hA5};
    add_frame(16'h0020, 1'b0, 0);
    send_stream(1);
    check_results("inband_sync");
  endtask

  task automatic test_reset_mid();
    logic [7:0] part[7];
    part = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34};
    @(negedge clk);
    foreach (part[i]) begin
      in_valid = 1'b1;
      in_data  = part[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cpu_hold !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: hold=%b rdy=%b we=%b expected 0 0 0", cpu_hold, in_ready, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_exp();
    pay_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    add_frame(16'h0010, 1'b0, 1);
    send_stream(0);
    check_results("reset_mid");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int n;
    logic [7:0] b;
    for (int f = 0; f < 8; f++) begin
      clear_exp();
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
      n = $urandom_range(0, 5);
      for (int i = 0; i < 2 * n; i++) begin
        b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
        pay_q.push_back(b);
      end
      add_frame(a, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      send_stream(2);
      check_results($sformatf("random%0d", f));
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    pay_q = '{8'h01, 8'h02};
    add_frame(16'h1000, 1'b0, 0);
    pay_q = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    add_frame(16'hFFFE, 1'b1, 0);
    add_frame(16'h0040, 1'b0, 0);
    send_stream(0);
    check_results("back_to_back");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_wrap_noise();
    test_zero_count();
    test_inband_sync();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
